// File: rtl/led_bank_ctrl_pkg.sv
// led_bank_ctrl_pkg: shared mode encoding and widths for the LED bank controller
package led_bank_ctrl_pkg;
    localparam int MODE_W = 2;
    localparam int CH_W   = 4;
    typedef enum logic [MODE_W-1:0] {
        LED_MODE_OFF   = 2'd0,
        LED_MODE_ON    = 2'd1,
        LED_MODE_BLINK = 2'd2,
        LED_MODE_PWM   = 2'd3
    } led_mode_e;
endpackage

// File: rtl/led_bank_ctrl_channel.sv
// led_channel: one LED channel with mode/duty registers and a registered output mux.
// Defining LED_ACTIVE_LOW_EN inverts the output register, including its reset value.
module led_channel import led_bank_ctrl_pkg::*; #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  led_mode_e           mode_i,
    input  logic [PWM_BITS-1:0] duty_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    input  logic                phase_i,
    output logic                led_o
);
`ifdef LED_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif
    led_mode_e           mode_q, mode_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                led_q, led_d;

    // Next-state for the configuration registers and the drive value from the current ones
    always_comb begin
        mode_d = we_i ? mode_i : mode_q;
        duty_d = we_i ? duty_i : duty_q;
        led_d  = INV ^ ((mode_q == LED_MODE_ON) ||
                        (mode_q == LED_MODE_BLINK && phase_i) ||
                        (mode_q == LED_MODE_PWM && pwm_cnt_i < duty_q));
    end

    // Channel state registers; output resets to the inactive level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= LED_MODE_OFF;
            duty_q <= '0;
            led_q  <= INV;
        end else begin
            mode_q <= mode_d;
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end

    assign led_o = led_q;
endmodule

// File: rtl/led_bank_ctrl.sv
// led_bank_ctrl: N_LED-channel LED driver with shared prescaler, PWM and blink timebases.
// Optional LED_ACTIVE_LOW_EN makes every led output active-low.
module led_bank_ctrl import led_bank_ctrl_pkg::*; #(
    parameter int N_LED       = 4,
    parameter int PRESCALE    = 1000,
    parameter int PWM_BITS    = 8,
    parameter int BLINK_TICKS = 250
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [MODE_W-1:0]   wr_mode,
    input  logic [PWM_BITS-1:0] wr_duty,
    output logic [N_LED-1:0]    led,
    output logic                tick
);
    localparam int PS_W = $clog2(PRESCALE);
    localparam int BL_W = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;

    logic [PS_W-1:0]     presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [BL_W-1:0]     blink_q, blink_d;
    logic                phase_q, phase_d;
    logic                tick_q, tick_en, bl_wrap;

    // Timebase next-state: the tick pulse is registered, counters advance on the same edge
    always_comb begin
        tick_en = presc_q == PS_W'(PRESCALE - 1);
        bl_wrap = tick_en && blink_q == BL_W'(BLINK_TICKS - 1);
        presc_d = tick_en ? '0 : presc_q + 1'b1;
        pwm_d   = tick_en ? pwm_q + 1'b1 : pwm_q;
        blink_d = bl_wrap ? '0 : tick_en ? blink_q + 1'b1 : blink_q;
        phase_d = phase_q ^ bl_wrap;
    end

    // Shared timebase registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            pwm_q   <= '0;
            blink_q <= '0;
            phase_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            tick_q  <= tick_en;
        end
    end

    assign tick = tick_q;

    // Out-of-range channel indices match no instance, so such writes vanish
    for (genvar i = 0; i < N_LED; i++) begin : g_ch
        led_channel #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .we_i      (wr_en && wr_ch == CH_W'(i)),
            .mode_i    (led_mode_e'(wr_mode)),
            .duty_i    (wr_duty),
            .pwm_cnt_i (pwm_q),
            .phase_i   (phase_q),
            .led_o     (led[i])
        );
    end
endmodule
